// File: rtl/fight_turn_controller.sv
// fight_turn_controller: turn sequencer for the two-player fighting game.
//
// Collects one action per player per turn, presents the pair to both player
// FSMs with a one-cycle actionEnable strobe, resets the player FSMs at the
// start of each game and watches both health buses for game over.
//
// Parameters:
//   MAX_TURNS  - turn limit (1..255); reaching it ends the game on health.
//   TURN_TICKS - COLLECT timeout in clk cycles (only with TURN_TIMEOUT_EN).
//
// Optional feature: define TURN_TIMEOUT_EN to fill a missing action with
// await (010) after TURN_TICKS cycles in COLLECT. Undefined: wait forever.
//
// Ports:
//   clk, reset (async, active-low)
//   start                    - pulse, starts a new game from IDLE/OVER
//   act1_valid/act1[2:0]     - player-1 action offer
//   act2_valid/act2[2:0]     - player-2 action offer
//   health1/health2[1:0]     - player health from the player FSMs
//   action1/action2[2:0]     - registered actions to the player FSMs
//   actionEnable             - one-cycle apply strobe
//   game_reset               - one-cycle reset pulse to the player FSMs
//   isGameOver, winner[1:0]  - game result (00 none, 01 p1, 10 p2, 11 draw)
//   turn_count[7:0]          - completed turns
//   busy                     - game in progress (CLEAR..SETTLE)
module fight_turn_controller #(
    parameter int MAX_TURNS  = 99,
    parameter int TURN_TICKS = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       act1_valid,
    input  logic [2:0] act1,
    input  logic       act2_valid,
    input  logic [2:0] act2,
    input  logic [1:0] health1,
    input  logic [1:0] health2,
    output logic [2:0] action1,
    output logic [2:0] action2,
    output logic       actionEnable,
    output logic       game_reset,
    output logic       isGameOver,
    output logic [1:0] winner,
    output logic [7:0] turn_count,
    output logic       busy
);
    typedef enum logic [2:0] {IDLE, CLEAR, COLLECT, COMMIT, SETTLE, OVER} state_t;
    localparam logic [2:0] AWAIT = 3'b010;

    state_t     state_q, state_d;
    logic       pend1_q, pend1_d, pend2_q, pend2_d;
    logic [2:0] slot1_q, slot1_d, slot2_q, slot2_d;
    logic [2:0] action1_q, action1_d, action2_q, action2_d;
    logic       action_enable_q, action_enable_d;
    logic       game_reset_q, game_reset_d;
    logic       game_over_q, game_over_d;
    logic       busy_q, busy_d;
    logic [1:0] winner_q, winner_d;
    logic [7:0] turn_q, turn_d, turn_inc;
    logic       timeout;

`ifdef TURN_TIMEOUT_EN
    localparam int TW = $clog2(TURN_TICKS + 1);
    logic [TW-1:0] tick_q, tick_d;
    // Counter is zero on every entry into COLLECT because it is held at
    // zero in all other states; timeout fires on the TURN_TICKS-th edge.
    assign timeout = (state_q == COLLECT) && (tick_q == TW'(TURN_TICKS - 1));
    assign tick_d  = (state_q == COLLECT) ? tick_q + 1'b1 : '0;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) tick_q <= '0;
        else        tick_q <= tick_d;
    end
`else
    logic unused_ticks;
    assign unused_ticks = |TURN_TICKS;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        pend1_d         = pend1_q;
        pend2_d         = pend2_q;
        slot1_d         = slot1_q;
        slot2_d         = slot2_q;
        action1_d       = action1_q;
        action2_d       = action2_q;
        action_enable_d = 1'b0;
        game_reset_d    = 1'b0;
        game_over_d     = game_over_q;
        winner_d        = winner_q;
        turn_d          = turn_q;
        turn_inc        = turn_q + 8'd1;
        case (state_q)
            IDLE, OVER: begin
                if (start) begin
                    state_d      = CLEAR;
                    game_reset_d = 1'b1;
                    turn_d       = 8'd0;
                    winner_d     = 2'b00;
                    game_over_d  = 1'b0;
                end
            end
            CLEAR: begin
                pend1_d = 1'b0;
                pend2_d = 1'b0;
                state_d = COLLECT;
            end
            COLLECT: begin
                // A real offer on the timeout edge takes priority over the fill.
                if (!pend1_q && (act1_valid || timeout)) begin
                    slot1_d = act1_valid ? act1 : AWAIT;
                    pend1_d = 1'b1;
                end
                if (!pend2_q && (act2_valid || timeout)) begin
                    slot2_d = act2_valid ? act2 : AWAIT;
                    pend2_d = 1'b1;
                end
                if (pend1_d && pend2_d) begin
                    state_d         = COMMIT;
                    action1_d       = slot1_d;
                    action2_d       = slot2_d;
                    action_enable_d = 1'b1;
                end
            end
            COMMIT: begin
                pend1_d = 1'b0;
                pend2_d = 1'b0;
                state_d = SETTLE;
            end
            SETTLE: begin
                // Player FSMs applied the actions on the COMMIT edge, so health is current here.
                if (health1 == 2'd0 || health2 == 2'd0) begin
                    state_d     = OVER;
                    game_over_d = 1'b1;
                    winner_d    = {health1 == 2'd0, health2 == 2'd0};
                end else begin
                    turn_d = turn_inc;
                    if (turn_inc == 8'(MAX_TURNS)) begin
                        state_d     = OVER;
                        game_over_d = 1'b1;
                        winner_d    = health1 > health2 ? 2'b01 :
                                      health1 < health2 ? 2'b10 : 2'b11;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = state_d inside {CLEAR, COLLECT, COMMIT, SETTLE};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            pend1_q         <= 1'b0;
            pend2_q         <= 1'b0;
            slot1_q         <= AWAIT;
            slot2_q         <= AWAIT;
            action1_q       <= AWAIT;
            action2_q       <= AWAIT;
            action_enable_q <= 1'b0;
            game_reset_q    <= 1'b0;
            game_over_q     <= 1'b0;
            winner_q        <= 2'b00;
            turn_q          <= 8'd0;
            busy_q          <= 1'b0;
        end else begin
            state_q         <= state_d;
            pend1_q         <= pend1_d;
            pend2_q         <= pend2_d;
            slot1_q         <= slot1_d;
            slot2_q         <= slot2_d;
            action1_q       <= action1_d;
            action2_q       <= action2_d;
            action_enable_q <= action_enable_d;
            game_reset_q    <= game_reset_d;
            game_over_q     <= game_over_d;
            winner_q        <= winner_d;
            turn_q          <= turn_d;
            busy_q          <= busy_d;
        end
    end

    assign action1      = action1_q;
    assign action2      = action2_q;
    assign actionEnable = action_enable_q;
    assign game_reset   = game_reset_q;
    assign isGameOver   = game_over_q;
    assign winner       = winner_q;
    assign turn_count   = turn_q;
    assign busy         = busy_q;
endmodule
